alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 205 ++++++++++++++++++++
 tb/tb_alu_iter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: request/response ALU with single-cycle logic/arith ops and
// iterative (one bit per cycle) multiply and unsigned divide.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   request present
//   in_ready   request can be accepted (IDLE and not in reset)
//   A, B       operands, captured on the accept edge
//   op         op[4]=0 single-cycle op[3:0]; op[4]=1 iterative op[1:0]
//   out_valid  Result/Zero hold a finished operation (DONE state)
//   out_ready  consumer takes the result, honoured only in DONE
//   Result     registered result
//   Zero       registered flag, Result == 0
//   busy       iterative operation in progress (CALC state)
module alu_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          accept;
    logic [CW-1:0] cnt;

    // Iterative datapath: hi is the partial product / remainder,
    // lo is the multiplier being consumed / quotient being built.
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b_q;
    logic [1:0]      sel_q;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;
    logic [XLEN-1:0] iter_y;

    logic [XLEN:0]   sum;
    logic [XLEN-1:0] rem_sh;
    logic            ge;

    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] ctz;
    logic [SHW-1:0]  shamt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid && ~reset) begin
                    accept  = 1'b1;
                    state_d = op[4] ? CALC : DONE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live inputs at the accept edge
    // ------------------------------------------------------------------
    always_comb begin
        ctz = XLEN'(XLEN);
        // Scan from the top so the lowest set bit is the last write.
        for (int unsigned i = XLEN; i > 0; i--) begin
            if (A[i-1]) begin
                ctz = XLEN'(i - 1);
            end
        end
    end

    always_comb begin
        shamt = B[SHW-1:0];
        alu_y = '0;
        case (op[3:0])
            4'h0: alu_y = A & B;
            4'h1: alu_y = A << shamt;
            4'h2: alu_y = A + B;
            4'h3: alu_y = A >> shamt;
            4'h4: alu_y = A ^ B;
            4'h5: alu_y = $signed(A) >>> shamt;
            4'h6: alu_y = A - B;
            4'h7: alu_y = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            4'h8: alu_y = {{(XLEN-1){1'b0}}, A < B};
            4'h9: alu_y = A | B;
            4'hA: alu_y = B;
            4'hB: alu_y = A;
            4'hC: alu_y = ~(A | B);
            4'hD: alu_y = ~(A & B);
            4'hE: alu_y = ~A;
            4'hF: alu_y = ctz;
            default: alu_y = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    always_comb begin
        sum    = '0;
        rem_sh = '0;
        ge     = 1'b0;
        hi_n   = hi;
        lo_n   = lo;
        if (sel_q[1]) begin
            // Remainder fits in XLEN bits after a successful subtract, so the
            // subtraction is done modulo 2^XLEN while the compare uses the
            // full XLEN+1 bit shifted remainder.
            rem_sh = {hi[XLEN-2:0], lo[XLEN-1]};
            ge     = {hi, lo[XLEN-1]} >= {1'b0, b_q};
            hi_n   = ge ? (rem_sh - b_q) : rem_sh;
            lo_n   = {lo[XLEN-2:0], ge};
        end else begin
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
        // MUL/DIVU read the low half, MULHU/REMU the high half.
        iter_y = sel_q[0] ? hi_n : lo_n;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
            Zero   <= 1'b1;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            b_q    <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            if (op[4]) begin
                hi    <= '0;
                lo    <= A;
                b_q   <= B;
                sel_q <= op[1:0];
                cnt   <= CW'(XLEN - 1);
            end else begin
                Result <= alu_y;
                Zero   <= (alu_y == '0);
            end
        end else if (state_q == CALC) begin
            hi <= hi_n;
            lo <= lo_n;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                Result <= iter_y;
                Zero   <= (iter_y == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed testbench for alu_iter (XLEN=32) with an expected-result
// scoreboard filled at issue time and drained when out_valid appears.
module tb_alu_iter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   B;
    logic [4:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   Result;
    logic              Zero;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];

    typedef struct {
        logic [4:0]      o;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        string           name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .busy      (busy)
    );

    function automatic logic [XLEN-1:0] model(input logic [4:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   r;
        int                k;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        r = '0;
        if (o[4]) begin
            case (o[1:0])
                2'd0: r = p[XLEN-1:0];
                2'd1: r = p[2*XLEN-1:XLEN];
                2'd2: r = (b == 0) ? {XLEN{1'b1}} : a / b;
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (o[3:0])
                4'h0: r = a & b;
                4'h1: r = a << b[4:0];
                4'h2: r = a + b;
                4'h3: r = a >> b[4:0];
                4'h4: r = a ^ b;
                4'h5: r = $signed(a) >>> b[4:0];
                4'h6: r = a - b;
                4'h7: r = ($signed(a) < $signed(b)) ? 1 : 0;
                4'h8: r = (a < b) ? 1 : 0;
                4'h9: r = a | b;
                4'hA: r = b;
                4'hB: r = a;
                4'hC: r = ~(a | b);
                4'hD: r = ~(a & b);
                4'hE: r = ~a;
                default: begin
                    k = 0;
                    while (k < XLEN && a[k] == 1'b0) k++;
                    r = k;
                end
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it for exactly the accept edge.
    task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_at_issue", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        exp_q.push_back(model(o, a, b));
        lat_q.push_back(o[4] ? XLEN + 1 : 1);
        @(posedge clk); #1;
        // Scramble inputs after capture; they must not affect the result.
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 5'($urandom);
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard, release.
    task automatic collect(input string tag);
        int n;
        int nb;
        int l;
        logic [XLEN-1:0] e;
        n = 0;
        nb = 0;
        while (!out_valid && n < 100) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk({tag, "_latency"}, n + 1, l);
        chk({tag, "_busy_cycles"}, nb, l - 1);
        chk({tag, "_result"}, Result, e);
        chk({tag, "_zero"}, Zero, (e == 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [XLEN-1:0] held;
        logic [XLEN-1:0] e;

        // Reset, with a request pending that must be ignored.
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        op = 5'h02;
        A = 32'd1;
        B = 32'd1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs", {out_valid, busy, Zero}, 3'b001);
        chk("reset_result", Result, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("post_reset_no_output", out_valid, 0);

        vecs.push_back('{5'h02, 32'hFFFFFFFF, 32'h00000001, "add_wrap"});
        vecs.push_back('{5'h05, 32'h80000000, 32'h00000024, "sra"});
        vecs.push_back('{5'h0F, 32'h00000000, 32'h12345678, "ctz_zero"});
        vecs.push_back('{5'h0F, 32'h00000100, 32'h00000000, "ctz_100"});
        vecs.push_back('{5'h0F, 32'h80000000, 32'h00000000, "ctz_msb"});
        vecs.push_back('{5'h00, 32'hF0F0F0F0, 32'hFF00FF00, "and"});
        vecs.push_back('{5'h01, 32'h00000001, 32'h0000003F, "sll"});
        vecs.push_back('{5'h03, 32'h80000000, 32'h00000021, "srl"});
        vecs.push_back('{5'h04, 32'hAAAA5555, 32'hFFFF0000, "xor"});
        vecs.push_back('{5'h06, 32'h00000000, 32'h00000001, "sub"});
        vecs.push_back('{5'h07, 32'hFFFFFFFF, 32'h00000001, "slt"});
        vecs.push_back('{5'h08, 32'hFFFFFFFF, 32'h00000001, "sltu"});
        vecs.push_back('{5'h09, 32'h12000034, 32'h00560000, "or"});
        vecs.push_back('{5'h0A, 32'h11111111, 32'h22222222, "pass_b"});
        vecs.push_back('{5'h0B, 32'h11111111, 32'h22222222, "pass_a"});
        vecs.push_back('{5'h0C, 32'h0F0F0000, 32'h0000F0F0, "nor"});
        vecs.push_back('{5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF, "nand"});
        vecs.push_back('{5'h0E, 32'h0000FFFF, 32'h00000000, "not"});
        vecs.push_back('{5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max"});
        vecs.push_back('{5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_max"});
        vecs.push_back('{5'h12, 32'd100, 32'd7, "divu"});
        vecs.push_back('{5'h13, 32'd100, 32'd7, "remu"});
        vecs.push_back('{5'h12, 32'd5, 32'd0, "divu_by0"});
        vecs.push_back('{5'h13, 32'd5, 32'd0, "remu_by0"});
        vecs.push_back('{5'h1D, 32'h12345678, 32'h9ABCDEF0, "mulhu_opx"});
        vecs.push_back('{5'h1E, 32'hDEADBEEF, 32'h00000010, "divu_opx"});
        vecs.push_back('{5'h10, $urandom, $urandom, "mul_rand"});
        vecs.push_back('{5'h13, $urandom, 32'h0000FFFF & $urandom, "remu_rand"});

        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b);
            collect(vecs[i].name);
        end

        // out_ready held high during CALC must not cut the operation short.
        out_ready = 1'b1;
        issue(5'h12, 32'd1000, 32'd3);
        out_ready = 1'b1;
        collect("divu_ready_early");

        // Backpressure: result held, no new request taken while in DONE.
        issue(5'h02, 32'd7, 32'd8);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        held = Result;
        e = exp_q.pop_front();
        void'(lat_q.pop_front());
        chk("hold_result", held, e);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            op = 5'h02;
            A = 32'd1;
            B = 32'd1;
            if (Result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("hold_stable_cycles_bad", seen, 0);
        in_valid = 1'b0;
        chk("hold_still_result", Result, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release_idle", {out_valid, in_ready}, 2'b01);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("hold_no_ghost_request", seen, 0);

        // Reset during a DIVU discards it.
        issue(5'h12, 32'hFFFF0000, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid_calc_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        chk("mid_reset_state", {out_valid, busy, Zero}, 3'b001);
        chk("mid_reset_result", Result, 0);
        seen = 0;
        repeat (40) begin
            if (out_valid || Result != 0) seen++;
            @(posedge clk); #1;
        end
        chk("mid_reset_no_stale", seen, 0);
        issue(5'h02, 32'd2, 32'd3);
        collect("add_after_reset");

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
